muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/div_core.sv | 72 +++++++
 rtl/muldiv_unit.sv | 120 ++++++++++++
 tb/tb_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM state codes,
// divider iteration count and a conditional two's-complement negate helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int DIV_ITERS = 32;

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider on operand magnitudes, with sign fix-up and the
// divide-by-zero result applied on the output side.
module div_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_done,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [31:0] r_a_raw;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [5:0]  r_cnt;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [32:0] w_trial;

    assign w_a_neg = i_signed & i_a[31];
    assign w_b_neg = i_signed & i_b[31];
    // Borrow out of the 33-bit trial subtract means the divisor did not fit.
    assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_div};
    assign o_done  = (r_cnt == 6'(DIV_ITERS));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_a_raw <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_cnt   <= 6'(DIV_ITERS);
        end else if (i_start) begin
            r_rem   <= '0;
            r_quo   <= cneg32(i_a, w_a_neg);
            r_div   <= cneg32(i_b, w_b_neg);
            r_a_raw <= i_a;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= (i_b == 32'd0);
            r_cnt   <= '0;
        end else if (!o_done) begin
            if (!w_trial[32]) begin
                r_rem <= w_trial[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= {r_rem[30:0], r_quo[31]};
                r_quo <= {r_quo[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // The most-negative / -1 case falls out naturally: magnitude quotient
    // 0x8000_0000 with no negation and a zero remainder.
    assign o_quo = r_dz ? 32'hFFFF_FFFF : cneg32(r_quo, r_neg_q);
    assign o_rem = r_dz ? r_a_raw : cneg32(r_rem, r_neg_r);

endmodule

// File: rtl/muldiv_unit.sv
// HILO multiply/divide unit: fixed-latency multiplier plus iterative divider.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        hilo_we,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] LAT_M1 = 2'(MUL_LATENCY - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;

    logic [1:0]  w_next;
    logic        w_accept;
    logic        w_msign;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic        w_div_done;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;

    assign busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign done      = (r_state == ST_DONE);
    assign hilo_we   = done;
    assign dbg_state = r_state;
    assign w_accept  = start & ~busy & ~flush;

    // Low 64 bits of a product of 64-bit extensions are exact for both signednesses.
    assign w_msign = (r_op == OP_MULT);
    assign w_ext_a = {{32{w_msign & r_a[31]}}, r_a};
    assign w_ext_b = {{32{w_msign & r_b[31]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

`ifdef MULDIV_DIV_EN
    div_core u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .i_start  (w_accept & op[1]),
        .i_signed (~op[0]),
        .i_a      (src_a),
        .i_b      (src_b),
        .o_done   (w_div_done),
        .o_quo    (w_div_q),
        .o_rem    (w_div_r)
    );
`else
    assign w_div_done = 1'b1;
    assign w_div_q    = '0;
    assign w_div_r    = '0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: w_next = w_accept ? (op[1] ? ST_DIV : ST_MUL) : ST_IDLE;
            ST_MUL: begin
                if (flush)                w_next = ST_IDLE;
                else if (r_cnt == 2'd0)   w_next = ST_DONE;
            end
            ST_DIV: begin
                if (flush)                w_next = ST_IDLE;
                else if (w_div_done)      w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= src_a;
                r_b   <= src_b;
                r_op  <= op;
                r_cnt <= LAT_M1;
            end else if (r_state == ST_MUL && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            // Results only move on entry to DONE, so they hold across flushes.
            if (w_next == ST_DONE) begin
                if (r_state == ST_MUL) begin
                    result_lo <= w_prod[31:0];
                    result_hi <= w_prod[63:32];
                end else begin
                    result_lo <= w_div_q;
                    result_hi <= w_div_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, flush/reset
// aborts, back-to-back starts and randomized operations against a reference model.
module tb_muldiv_unit;

    localparam int LAT = 2;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        hilo_we;
    logic [1:0]  dbg_state;

    int          n_vec;
    int          n_err;
    logic [63:0] last_exp;

    muldiv_unit #(.MUL_LATENCY(LAT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .hilo_we   (hilo_we),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi, lo} from the architectural rules, using plain SV arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        logic [63:0]     res;
        res = 64'd0;
        if (o == 2'b00) begin
            sp  = longint'($signed(a)) * longint'($signed(b));
            res = sp;
        end else if (o == 2'b01) begin
            up  = {32'd0, a} * {32'd0, b};
            res = up;
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) begin
                res = {a, 32'hFFFF_FFFF};
            end else if (o == 2'b10) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = {32'h0, 32'h8000_0000};
                end else begin
                    q   = $signed(a) / $signed(b);
                    r   = $signed(a) % $signed(b);
                    res = {r, q};
                end
            end else begin
                res = {a % b, a / b};
            end
`else
            res = 64'd0;
`endif
        end
        return res;
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
        return o[1] ? 33 : LAT;
`else
        return o[1] ? 1 : LAT;
`endif
    endfunction

    // Called at a negedge with the unit able to accept (unless pre=1, where the
    // previous call already drove start in its DONE cycle).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, input bit pre, input bit chain,
                          input logic [1:0] o2, input logic [31:0] a2, input logic [31:0] b2);
        logic [63:0] exp;
        int          k;
        int          lat;
        exp = model(o, a, b);
        lat = exp_lat(o);
        if (!pre) begin
            start = 1'b1; op = o; src_a = a; src_b = b;
        end
        @(negedge clk);
        k = 0;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("no_done_at_accept", 64'(done), 64'd0);
        while (!done && k < 100) begin
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            op    = 2'($urandom_range(0, 3));
            src_a = $urandom;
            src_b = $urandom;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", 64'(done), 64'd1);
        if (!done) return;
        check("latency", 64'(k), 64'(lat));
        check("result", {result_hi, result_lo}, exp);
        check("hilo_we", 64'(hilo_we), 64'd1);
        last_exp = exp;
        if (chain) begin
            start = 1'b1; op = o2; src_a = a2; src_b = b2;
        end else begin
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_after_done", 64'(busy), 64'd0);
            check("result_hold", {result_hi, result_lo}, exp);
        end
    endtask

    task automatic flush_test(input logic [1:0] o, input int at);
        bit seen;
        start = 1'b1; op = o; src_a = $urandom; src_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (at) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_no_done", 64'(done), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= done;
        end
        check("flush_silent", 64'(seen), 64'd0);
        check("flush_hold", {result_hi, result_lo}, last_exp);
    endtask

    initial begin
        bit          seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        n_vec = 0; n_err = 0; last_exp = '0;
        resetn = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo_we", 64'(hilo_we), 64'd0);
        check("rst_result", {result_hi, result_lo}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed corners
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);

        // Back-to-back: start accepted in the DONE cycle
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFF_FF00, 32'd7);
        run_op(2'b10, 32'hFFFF_FF00, 32'd7, 1'b0, 1'b1, 1'b1, 2'b00, 32'hFFFF_0000, 32'd3);
        run_op(2'b00, 32'hFFFF_0000, 32'd3, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);

        // Flush aborts
`ifdef MULDIV_DIV_EN
        flush_test(2'b10, 9);
`endif
        flush_test(2'b00, 0);

        // Flush suppresses a start in the same cycle
        start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_blocks_start", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= done;
        end
        check("flush_start_silent", 64'(seen), 64'd0);

        // Reset mid-multiply
        start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", {result_hi, result_lo}, 64'd0);
        seen = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            seen |= done;
        end
        check("midrst_silent", 64'(seen), 64'd0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
